// File: rtl/banco_campos_cfg_pkg.sv
// Shared definitions for the configuration field bank: modo encodings, default limits, repeat timing.
// Default limits describe NG=3 groups (hora, fecha, timer) of NF=3 fields, W=7 bits each.
package banco_campos_cfg_pkg;

    typedef enum logic [1:0] {
        MODO_NORMAL = 2'd0,
        MODO_HORA   = 2'd1,
        MODO_FECHA  = 2'd2,
        MODO_TIMER  = 2'd3
    } modo_e;

    localparam int CFG_NG = 3;
    localparam int CFG_NF = 3;
    localparam int CFG_W  = 7;

    // Packed low field first: {timer f2..f0, fecha f2..f0, hora f2..f0}
    localparam logic [CFG_NG*CFG_NF*CFG_W-1:0] CFG_FIELD_MIN = {
        7'd0,  7'd0,  7'd0,
        7'd1,  7'd1,  7'd0,
        7'd0,  7'd0,  7'd0
    };
    localparam logic [CFG_NG*CFG_NF*CFG_W-1:0] CFG_FIELD_MAX = {
        7'd23, 7'd59, 7'd59,
        7'd31, 7'd12, 7'd99,
        7'd23, 7'd59, 7'd59
    };

    localparam int REPEAT_DLY = 50_000_000;
    localparam int REPEAT_PER = 10_000_000;

endpackage

// File: rtl/banco_campos_cfg_contador_campo.sv
// One editable field: W-bit up/down register wrapping between MIN and MAX, with a clamped parallel load.
module contador_campo #(
    parameter int            W   = 7,
    parameter logic [W-1:0]  MIN = '0,
    parameter logic [W-1:0]  MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_dat,
    output logic [W-1:0] valor
);

    function automatic logic [W-1:0] saturar(input logic [W-1:0] d);
        if (d < MIN)
            return MIN;
        else if (d > MAX)
            return MAX;
        else
            return d;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valor <= MIN;
        else if (load)
            valor <= saturar(load_dat);
        else if (inc && !dec)
            valor <= (valor >= MAX) ? MIN : valor + W'(1);
        else if (dec && !inc)
            valor <= (valor <= MIN) ? MAX : valor - W'(1);
    end

endmodule

// File: rtl/banco_campos_cfg.sv
// Bank of editable time/date/timer fields with cursor, button edge detection and commit on group exit.
// Optional build macro HOLD_REPEAT_EN adds auto-repeat for held arriba/abajo.
module banco_campos_cfg
    import banco_campos_cfg_pkg::*;
#(
    parameter int                   NG        = CFG_NG,
    parameter int                   NF        = CFG_NF,
    parameter int                   W         = CFG_W,
    parameter logic [NG*NF*W-1:0]   FIELD_MIN = CFG_FIELD_MIN,
    parameter logic [NG*NF*W-1:0]   FIELD_MAX = CFG_FIELD_MAX,
    localparam int                  MW        = $clog2(NG + 1),
    localparam int                  PW        = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [MW-1:0]       modo,
    input  logic                arriba,
    input  logic                abajo,
    input  logic                izquierda,
    input  logic                derecha,
    input  logic                carga,
    input  logic [NG*NF*W-1:0]  carga_dat,
    output logic [NG*NF*W-1:0]  campos,
    output logic [PW-1:0]       pos_cursor,
    output logic                commit,
    output logic [MW-1:0]       commit_grupo
);

    logic [MW-1:0] modo_ef;
    logic [MW-1:0] modo_q;
    logic          arriba_q, abajo_q, izq_q, der_q;
    logic          tick_arr, tick_aba, tick_izq, tick_der;
    logic          cambio, activo, carga_ok;
    logic          paso_arr, paso_aba;

    assign modo_ef  = (modo > MW'(NG)) ? MW'(MODO_NORMAL) : modo;
    assign cambio   = (modo_ef != modo_q);
    assign activo   = (modo_ef != '0) && !cambio;
    assign carga_ok = carga && (modo_ef == '0);

    assign tick_arr = arriba    & ~arriba_q;
    assign tick_aba = abajo     & ~abajo_q;
    assign tick_izq = izquierda & ~izq_q;
    assign tick_der = derecha   & ~der_q;

    // Edge registers start high so a button held through reset never ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arriba_q <= 1'b1;
            abajo_q  <= 1'b1;
            izq_q    <= 1'b1;
            der_q    <= 1'b1;
            modo_q   <= '0;
        end else begin
            arriba_q <= arriba;
            abajo_q  <= abajo;
            izq_q    <= izquierda;
            der_q    <= derecha;
            modo_q   <= modo_ef;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pos_cursor <= '0;
        else if (cambio || modo_ef == '0)
            pos_cursor <= '0;
        else if (tick_izq && !tick_der)
            pos_cursor <= (pos_cursor == PW'(NF - 1)) ? '0 : pos_cursor + PW'(1);
        else if (tick_der && !tick_izq)
            pos_cursor <= (pos_cursor == '0) ? PW'(NF - 1) : pos_cursor - PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit       <= 1'b0;
            commit_grupo <= '0;
        end else begin
            commit       <= cambio && (modo_q != '0);
            commit_grupo <= (cambio && (modo_q != '0)) ? modo_q : '0;
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam int RW = $clog2((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);

    logic [RW-1:0] rep_cnt;
    logic          rep_fase;
    logic          rep_held;
    logic          rep_pulso;

    // Counter restarts on any fresh press so only continuous single-button holds repeat
    assign rep_held  = (arriba ^ abajo) && activo;
    assign rep_pulso = rep_held && !tick_arr && !tick_aba &&
                       (rep_fase ? (rep_cnt == RW'(REPEAT_PER - 1))
                                 : (rep_cnt == RW'(REPEAT_DLY - 1)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_cnt  <= '0;
            rep_fase <= 1'b0;
        end else if (!rep_held || tick_arr || tick_aba) begin
            rep_cnt  <= '0;
            rep_fase <= 1'b0;
        end else if (rep_pulso) begin
            rep_cnt  <= '0;
            rep_fase <= 1'b1;
        end else begin
            rep_cnt  <= rep_cnt + RW'(1);
        end
    end

    assign paso_arr = (tick_arr | (rep_pulso & arriba)) & ~(tick_aba | (rep_pulso & abajo));
    assign paso_aba = (tick_aba | (rep_pulso & abajo))  & ~(tick_arr | (rep_pulso & arriba));
`else
    assign paso_arr = tick_arr & ~tick_aba;
    assign paso_aba = tick_aba & ~tick_arr;
`endif

    // Steps use the registered cursor, i.e. the position before any same-cycle move
    for (genvar k = 0; k < NG * NF; k++) begin : g_campo
        localparam logic [MW-1:0] GRP = MW'(k / NF + 1);
        localparam logic [PW-1:0] FLD = PW'(k % NF);

        logic sel;
        assign sel = activo && (modo_ef == GRP) && (pos_cursor == FLD);

        contador_campo #(
            .W   (W),
            .MIN (FIELD_MIN[k*W +: W]),
            .MAX (FIELD_MAX[k*W +: W])
        ) u_campo (
            .clk      (clk),
            .reset    (reset),
            .inc      (sel & paso_arr),
            .dec      (sel & paso_aba),
            .load     (carga_ok),
            .load_dat (carga_dat[k*W +: W]),
            .valor    (campos[k*W +: W])
        );
    end

endmodule
